grey_stream_ctrl: RTL and testbench
===================================

Name: grey_stream_ctrl

Overview:
- Streaming controller that sequences RGB pixels from the capture side through the shared RGB-to-greyscale converter into the frame-buffer write path.
- Provides valid/ready flow control with a 2-entry output buffer, so downstream stalls never drop pixels.
- Tracks the raster position and tags each output pixel with start-of-frame and end-of-line.
- Applies a per-frame conversion mode: grey, or bypass.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- XW, 10, width of the x counter; must satisfy 2^XW >= H_ACTIVE.
- YW, 9, width of the y counter; must satisfy 2^YW >= V_ACTIVE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_req  in  1  requested mode: 0 = grey, 1 = bypass. Sampled only at frame start.
- sync_clr  in  1  synchronous frame abort: flushes the buffer and zeroes the counters.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_rgb  in  24  input pixel {R[23:16], G[15:8], B[7:0]}.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_rgb  out  24  output pixel.
- out_sof  out  1  output pixel is x=0, y=0.
- out_eol  out  1  output pixel is x=H_ACTIVE-1.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted at the input.
- mode_act  out  1  mode applied to the current frame.

Behaviour:
- Reset values (rst_n=0, asynchronous): in_ready=0 while reset is asserted, then 1 after release; out_valid=0; out_rgb=0; out_sof=0; out_eol=0; frame_done=0; mode_act=0; x=0; y=0; buffer empty.
- Input accept: occurs when in_valid & in_ready at a clock edge. in_ready = buffer not full. The buffer is a 2-entry FIFO holding {rgb, sof, eol}.
- Grey arithmetic, combinational on in_rgb:
  - s = R+G+B (10 bits).
  - p = s*11 (14 bits).
  - g = p>>5.
  - grey = (g>255) ? 8'hFF : g[7:0].
  - Grey mode writes {grey, grey, grey} into the buffer. Bypass mode writes in_rgb unchanged.
- Latency: an accepted pixel appears at out_rgb/out_valid on the next cycle when the buffer was empty. Throughput is 1 pixel per clock while out_ready=1.
- Output handshake:
  - out_valid = buffer not empty; out_rgb, out_sof and out_eol always show the head entry.
  - An entry pops when out_valid & out_ready.
  - Simultaneous push and pop with 1 entry: the count stays 1 and the head advances.
  - Push with 2 entries is impossible, because in_ready=0.
  - Output data must stay stable while out_valid=1 and out_ready=0.
- Raster counters advance on each input accept:
  - x increments; at H_ACTIVE-1, x wraps to 0 and y increments.
  - At x=H_ACTIVE-1 and y=V_ACTIVE-1, both wrap to 0 and frame_done pulses in the same cycle as the accept is registered.
  - sof tag = (x==0 && y==0) at accept; eol tag = (x==H_ACTIVE-1).
- Mode latch: mode_act <= mode_req on accept of the sof pixel, and that pixel itself uses mode_req. mode_req changes mid-frame are ignored.
- sync_clr=1:
  - Empties the buffer, so out_valid=0 the next cycle.
  - Zeroes x and y; mode_act is held.
  - Any input accept in the same cycle is discarded.
  - in_ready stays 1.
- Reset mid-frame: all state returns to reset values immediately; the next accepted pixel is tagged sof.

Test Plan:
- Reset, then one pixel 0x646464 in grey mode with out_ready=1 -> next cycle out_valid=1, out_rgb=0x676767 (103), out_sof=1.
- Pixel 0xFFFFFF in grey mode -> out_rgb=0xFFFFFF (saturated, raw value 262); pixel 0x000000 -> out_rgb=0x000000.
- Backpressure: out_ready=0, 3 pixels offered back-to-back:
  - in_ready drops after 2 accepts; out_rgb holds the first pixel.
  - After out_ready=1, all three pixels emerge in order with no loss.
- With H_ACTIVE=4, V_ACTIVE=2, stream 8 pixels:
  - out_eol on pixels 3 and 7; out_sof on pixel 0 only; frame_done pulses once when pixel 7 is accepted.
  - A 9th pixel carries out_sof=1.
- mode_req=1 at the sof accept, then toggled to 0 mid-frame -> the whole frame is bypass (out_rgb=in_rgb, mode_act=1); the next frame is grey.
- sync_clr with 2 entries buffered, and rst_n pulsed low mid-line -> out_valid=0, and the next accepted pixel carries out_sof=1.

Source files
------------

// File: rtl/grey_stream_if.sv
// Pixel stream bundle between capture, the grey controller and the frame-buffer write path.
// The slave view is the controller's; the master view is the surrounding logic or bench.
interface grey_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic        out_sof;
  logic        out_eol;

  modport slave (
    input  in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_rgb, out_sof, out_eol
  );

  modport master (
    output in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_rgb, out_sof, out_eol
  );
endinterface

// File: rtl/grey_stream_ctrl.sv
// RGB->grey streaming controller: raster tagging, per-frame mode, and a 2-entry output FIFO
// so downstream stalls never lose a pixel.
module grey_stream_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_req,
  input  logic sync_clr,
  output logic frame_done,
  output logic mode_act,
  grey_stream_if.slave s
);
  typedef struct packed {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
  } ent_t;

  localparam logic [XW-1:0] XLAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLAST = YW'(V_ACTIVE - 1);

  ent_t          mem_q [2];
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          mode_q, mode_d;
  logic          fd_q, fd_d;
  logic          rdy_q;

  logic       acc, push, pop, sof_t, eol_t, last, mode_use;
  logic [9:0] sum;
  logic [13:0] prod;
  logic [8:0] g;
  logic [7:0] grey;
  ent_t       ent_in;

  // in_ready is held low through reset; a sync_clr cycle never blocks input.
  assign s.in_ready  = rdy_q & ((cnt_q != 2'd2) | sync_clr);
  assign s.out_valid = (cnt_q != 2'd0);
  assign s.out_rgb   = mem_q[rd_q].rgb;
  assign s.out_sof   = mem_q[rd_q].sof;
  assign s.out_eol   = mem_q[rd_q].eol;
  assign frame_done  = fd_q;
  assign mode_act    = mode_q;

  assign acc  = s.in_valid & s.in_ready;
  assign push = acc & ~sync_clr;
  assign pop  = s.out_valid & s.out_ready;

  assign sof_t    = (x_q == '0) && (y_q == '0);
  assign eol_t    = (x_q == XLAST);
  assign last     = eol_t && (y_q == YLAST);
  assign mode_use = sof_t ? mode_req : mode_q;

  // grey = sat8(((R+G+B)*11) >> 5), roughly the channel mean.
  assign sum  = {2'b0, s.in_rgb[23:16]} + {2'b0, s.in_rgb[15:8]} + {2'b0, s.in_rgb[7:0]};
  assign prod = {4'b0, sum} * 14'd11;
  assign g    = prod[13:5];
  assign grey = g[8] ? 8'hFF : g[7:0];

  assign ent_in.rgb = mode_use ? s.in_rgb : {grey, grey, grey};
  assign ent_in.sof = sof_t;
  assign ent_in.eol = eol_t;

  always_comb begin
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    fd_d   = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      x_d   = '0;
      y_d   = '0;
    end else begin
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      if (push) begin
        if (sof_t) mode_d = mode_req;
        if (eol_t) begin
          x_d = '0;
          y_d = last ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        fd_d = last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= 1'b0;
      fd_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      fd_q   <= fd_d;
      rdy_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= ent_in;
    end
  end
endmodule

// File: tb/tb_grey_stream_ctrl.sv
// Bench for grey_stream_ctrl on a 4x2 raster: directed vectors, corner sequences,
// then random traffic against a queue-based reference model.
module tb_grey_stream_ctrl;
  localparam int H = 4;
  localparam int V = 2;
  localparam int FRAME = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_req = 1'b0;
  logic sync_clr = 1'b0;
  logic frame_done, mode_act;
  int n_cmp = 0;
  int n_fail = 0;

  grey_stream_if bus();

  grey_stream_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(2), .YW(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .sync_clr(sync_clr),
    .frame_done(frame_done), .mode_act(mode_act), .s(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic [23:0] exp_rgb;
  } vec_t;

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] grey_ref(input logic [23:0] c);
    int v;
    v = ((int'(c[23:16]) + int'(c[15:8]) + int'(c[7:0])) * 11) / 32;
    if (v > 255) v = 255;
    return {3{v[7:0]}};
  endfunction

  vec_t tbl [8];
  ent_t q [$];
  int   pos;
  logic mode_f, fd_exp, exp_rdy, acc, pop;
  logic [23:0] px;

  initial begin
    tbl[0] = '{24'h646464, 24'h676767};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF};
    tbl[2] = '{24'h000000, 24'h000000};
    tbl[3] = '{24'h102030, 24'h212121};
    tbl[4] = '{24'hFF0000, 24'h575757};
    tbl[5] = '{24'h808080, 24'h848484};
    tbl[6] = '{24'hFFFFF0, 24'hFFFFFF};
    tbl[7] = '{24'hFFFFE0, 24'hFCFCFC};

    bus.in_valid = 1'b0; bus.in_rgb = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rgb", bus.out_rgb, 0);
    chk("rst_sof_eol", {bus.out_sof, bus.out_eol}, 0);
    chk("rst_fd_mode", {frame_done, mode_act}, 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_in_ready", bus.in_ready, 1);

    // One full grey frame, back-to-back with out_ready high.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_rgb = tbl[i].rgb;
      cyc();
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("tbl%0d_rgb", i), bus.out_rgb, tbl[i].exp_rgb);
      chk($sformatf("tbl%0d_sof", i), bus.out_sof, (i == 0));
      chk($sformatf("tbl%0d_eol", i), bus.out_eol, (i % 4 == 3));
      chk($sformatf("tbl%0d_fdone", i), frame_done, (i == 7));
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("tbl_drain_valid", bus.out_valid, 0);
    chk("tbl_fdone_once", frame_done, 0);

    // Backpressure: third pixel must wait, order preserved.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_rgb = 24'h646464; cyc();
    chk("bp_9th_sof", bus.out_sof, 1);
    bus.in_rgb = 24'h000000; cyc();
    bus.in_rgb = 24'hFFFFFF; #1;
    chk("bp_full_ready", bus.in_ready, 0);
    chk("bp_hold_rgb", bus.out_rgb, 24'h676767);
    cyc();
    chk("bp_stall_ready", bus.in_ready, 0);
    chk("bp_stall_rgb", bus.out_rgb, 24'h676767);
    bus.out_ready = 1'b1; cyc();
    chk("bp_pix1", bus.out_rgb, 24'h000000);
    chk("bp_pix1_valid", bus.out_valid, 1);
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_pix2", bus.out_rgb, 24'hFFFFFF);
    chk("bp_pix2_sof", bus.out_sof, 0);
    cyc();
    chk("bp_empty", bus.out_valid, 0);

    sync_clr = 1'b1; cyc(); sync_clr = 1'b0;

    // Bypass frame: mode_req only counts at the sof pixel.
    mode_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      px = 24'h123456 + 24'(i * 24'h0F1D2B);
      bus.in_valid = 1'b1; bus.in_rgb = px;
      cyc();
      mode_req = 1'b0;
      chk($sformatf("byp%0d_rgb", i), bus.out_rgb, px);
      chk($sformatf("byp%0d_mode", i), mode_act, 1);
    end
    bus.in_rgb = 24'h646464; cyc();
    chk("next_grey_rgb", bus.out_rgb, 24'h676767);
    chk("next_grey_mode", mode_act, 0);
    chk("next_grey_sof", bus.out_sof, 1);

    // sync_clr with two entries buffered and an input offered in the same cycle.
    bus.out_ready = 1'b0;
    bus.in_rgb = 24'h111111; cyc();
    bus.in_rgb = 24'h222222; cyc();
    sync_clr = 1'b1; bus.in_rgb = 24'h333333; #1;
    chk("clr_in_ready", bus.in_ready, 1);
    cyc();
    sync_clr = 1'b0; bus.in_valid = 1'b0;
    chk("clr_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_rgb = 24'h000000; cyc();
    chk("clr_next_sof", bus.out_sof, 1);
    chk("clr_next_valid", bus.out_valid, 1);

    // Asynchronous reset mid-line.
    bus.out_ready = 1'b0; bus.in_rgb = 24'h444444; cyc();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("arst_rel_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_rgb = 24'h646464; cyc();
    chk("arst_next_sof", bus.out_sof, 1);
    chk("arst_next_rgb", bus.out_rgb, 24'h676767);
    bus.in_valid = 1'b0; sync_clr = 1'b1; cyc(); sync_clr = 1'b0;

    // Random traffic against the reference model.
    pos = 0; mode_f = 1'b0; fd_exp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_out_valid", bus.out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_out_rgb", bus.out_rgb, q[0].rgb);
        chk("rnd_out_tags", {bus.out_sof, bus.out_eol}, {q[0].sof, q[0].eol});
      end
      chk("rnd_frame_done", frame_done, fd_exp);
      chk("rnd_mode_act", mode_act, mode_f);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      mode_req      = $urandom_range(1);
      sync_clr      = ($urandom_range(63) == 0);
      bus.in_rgb    = ($urandom_range(3) == 0) ? (24'hE0E0E0 | 24'($urandom)) : 24'($urandom);
      #1;
      exp_rdy = (q.size() < 2) || sync_clr;
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      acc = bus.in_valid && exp_rdy;
      pop = (q.size() > 0) && bus.out_ready;
      @(posedge clk);
      fd_exp = 1'b0;
      if (sync_clr) begin
        q.delete();
        pos = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          if (pos == 0) mode_f = mode_req;
          q.push_back('{mode_f ? bus.in_rgb : grey_ref(bus.in_rgb), pos == 0, (pos % H) == H - 1});
          fd_exp = (pos == FRAME - 1);
          pos = (pos + 1) % FRAME;
        end
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
